// File: rtl/class_argmax.sv
`default_nettype none
// ==== class_argmax (rev 1.0): scans NUM_CLASSES signed gSRAM scores and returns the arg-max over valid/ready ====
// ==== Define CLASS_ARGMAX_RUNNER_UP_EN to add the runner-up index (second_idx) and best-minus-runner-up margin ====
module class_argmax #(
    parameter int DATA_W      = 16,
    parameter int NUM_CLASSES = 10,
    parameter int ADDR_W      = 4,
    parameter int RD_LAT      = 1,
    parameter int SCORE_ROW   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_row,
    output logic [ADDR_W-1:0] rd_col,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] class_idx,
`ifdef CLASS_ARGMAX_RUNNER_UP_EN
    output logic [ADDR_W-1:0] second_idx,
    output logic [DATA_W:0]   margin,
`endif
    output logic [DATA_W-1:0] class_score
);
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                   state;
    logic [RD_LAT-1:0]        tag_valid;
    logic [ADDR_W-1:0]        tag_col [RD_LAT];
    logic signed [DATA_W-1:0] best_score;
    logic [ADDR_W-1:0]        best_idx;
    logic signed [DATA_W-1:0] data_s;
    logic                     ret_valid;
    logic [ADDR_W-1:0]        ret_col;
    logic                     in_flight;
`ifdef CLASS_ARGMAX_RUNNER_UP_EN
    logic signed [DATA_W-1:0] sec_score;
    logic [ADDR_W-1:0]        sec_idx;
    logic                     sec_valid;
`endif

    assign data_s    = rd_data;
    assign ret_valid = tag_valid[RD_LAT-1];
    assign ret_col   = tag_col[RD_LAT-1];
    assign in_flight = |tag_valid;
    assign rd_row    = ADDR_W'(SCORE_ROW);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rd_en       <= 1'b0;
            rd_col      <= '0;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            class_idx   <= '0;
            class_score <= '0;
`ifdef CLASS_ARGMAX_RUNNER_UP_EN
            second_idx  <= '0;
            margin      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= ISSUE;
                        rd_en  <= 1'b1;
                        rd_col <= '0;
                        busy   <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (rd_col == LAST_COL) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        rd_col <= rd_col + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    // Empty tag pipe means the final compare has already landed in best_*.
                    if (!in_flight && !rd_en) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        out_valid   <= 1'b1;
                        class_idx   <= best_idx;
                        class_score <= best_score;
`ifdef CLASS_ARGMAX_RUNNER_UP_EN
                        second_idx  <= sec_valid ? sec_idx : '0;
                        margin      <= sec_valid ? ({best_score[DATA_W-1], best_score}
                                                   - {sec_score[DATA_W-1], sec_score}) : '0;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_valid  <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_col[i] <= '0;
            best_score <= '0;
            best_idx   <= '0;
`ifdef CLASS_ARGMAX_RUNNER_UP_EN
            sec_score  <= '0;
            sec_idx    <= '0;
            sec_valid  <= 1'b0;
`endif
        end else begin
            tag_valid[0] <= rd_en;
            tag_col[0]   <= rd_col;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_col[i]   <= tag_col[i-1];
            end
            if (ret_valid) begin
                if (ret_col == '0) begin
                    best_score <= data_s;
                    best_idx   <= '0;
`ifdef CLASS_ARGMAX_RUNNER_UP_EN
                    sec_valid  <= 1'b0;
                    sec_score  <= '0;
                    sec_idx    <= '0;
`endif
                end else if (data_s > best_score) begin
                    best_score <= data_s;
                    best_idx   <= ret_col;
`ifdef CLASS_ARGMAX_RUNNER_UP_EN
                    sec_valid  <= 1'b1;
                    sec_score  <= best_score;
                    sec_idx    <= best_idx;
`endif
                end
`ifdef CLASS_ARGMAX_RUNNER_UP_EN
                else if (!sec_valid || data_s > sec_score) begin
                    sec_valid <= 1'b1;
                    sec_score <= data_s;
                    sec_idx   <= ret_col;
                end
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_class_argmax.sv
`timescale 1ns/1ps
`default_nettype none
// Two instances (read latency 1 and 3) share stimulus; each has its own gSRAM model and host.
module tb_class_argmax;
    localparam int DW = 16;
    localparam int N  = 10;
    localparam int AW = 4;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [DW-1:0] score;
        logic [AW-1:0] sidx;
        logic [DW:0]   margin;
        int            t;
        int            w;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    out_ready = 2'b00;
    logic          rd_en [2];
    logic [AW-1:0] rd_row [2];
    logic [AW-1:0] rd_col [2];
    logic [DW-1:0] rd_data [2];
    logic          busy [2];
    logic          out_valid [2];
    logic [AW-1:0] class_idx [2];
    logic [DW-1:0] class_score [2];
`ifdef CLASS_ARGMAX_RUNNER_UP_EN
    logic [AW-1:0] second_idx [2];
    logic [DW:0]   margin [2];
`endif

    logic [DW-1:0] mem [16];
    logic [DW-1:0] junk = '0;
    int            cyc = 0;
    exp_t          q[$];
    int            head [2];
    int            vcnt [2];
    int            rdcnt [2];
    logic          pv_prev [2];
    int            n_chk = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    class_argmax #(.DATA_W(DW), .NUM_CLASSES(N), .ADDR_W(AW), .RD_LAT(1), .SCORE_ROW(0)) dut1 (
        .clk(clk), .reset(reset), .start(start), .rd_en(rd_en[0]), .rd_row(rd_row[0]),
        .rd_col(rd_col[0]), .rd_data(rd_data[0]), .busy(busy[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .class_idx(class_idx[0]),
`ifdef CLASS_ARGMAX_RUNNER_UP_EN
        .second_idx(second_idx[0]), .margin(margin[0]),
`endif
        .class_score(class_score[0]));

    class_argmax #(.DATA_W(DW), .NUM_CLASSES(N), .ADDR_W(AW), .RD_LAT(3), .SCORE_ROW(0)) dut3 (
        .clk(clk), .reset(reset), .start(start), .rd_en(rd_en[1]), .rd_row(rd_row[1]),
        .rd_col(rd_col[1]), .rd_data(rd_data[1]), .busy(busy[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .class_idx(class_idx[1]),
`ifdef CLASS_ARGMAX_RUNNER_UP_EN
        .second_idx(second_idx[1]), .margin(margin[1]),
`endif
        .class_score(class_score[1]));

    // gSRAM models: data only valid in the return slot, random junk otherwise.
    logic          pv1 = 1'b0;
    logic [AW-1:0] pc1 = '0;
    logic [2:0]    pv3 = '0;
    logic [AW-1:0] pc3 [3];
    always @(posedge clk) begin
        junk   <= DW'($urandom);
        pv1    <= rd_en[0];
        pc1    <= rd_col[0];
        pv3    <= {pv3[1:0], rd_en[1]};
        pc3[0] <= rd_col[1];
        pc3[1] <= pc3[0];
        pc3[2] <= pc3[1];
    end
    assign rd_data[0] = pv1 ? mem[pc1] : junk;
    assign rd_data[1] = pv3[2] ? mem[pc3[2]] : junk;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut_lat%0d: got %0h expected %0h (cycle %0d)", name, lat_of(k), act, exp, cyc);
        end
    endtask

    // Reference: plain arg-max with lowest index on ties; runner-up is the arg-max of the rest.
    function automatic exp_t ref_model(input int w);
        exp_t e;
        int   bi, si, d;
        bi = 0;
        for (int i = 1; i < N; i++)
            if ($signed(mem[i]) > $signed(mem[bi])) bi = i;
        si = -1;
        for (int i = 0; i < N; i++)
            if (i != bi && (si < 0 || $signed(mem[i]) > $signed(mem[si]))) si = i;
        e.idx   = AW'(bi);
        e.score = mem[bi];
        e.sidx  = (si < 0) ? '0 : AW'(si);
        d       = (si < 0) ? 0 : (int'($signed(mem[bi])) - int'($signed(mem[si])));
        e.margin = (DW+1)'(d);
        e.t = 0;
        e.w = w;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        int   w;
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                chk("reset_state", k, 32'({rd_en[k], busy[k], out_valid[k], rd_col[k], rd_row[k],
                                           class_idx[k], class_score[k]}), 32'd0);
`ifdef CLASS_ARGMAX_RUNNER_UP_EN
                chk("reset_runner_up", k, 32'({second_idx[k], margin[k]}), 32'd0);
`endif
                head[k] = q.size();
                vcnt[k] = 0;
                rdcnt[k] = 0;
                pv_prev[k] = 1'b0;
                out_ready[k] = 1'b0;
            end else begin
                if (rd_en[k]) begin
                    chk("rd_col", k, 32'(rd_col[k]), 32'(rdcnt[k]));
                    chk("rd_row_busy", k, 32'({rd_row[k], busy[k]}), 32'({4'd0, 1'b1}));
                    rdcnt[k]++;
                end
                if (out_valid[k] && !pv_prev[k]) begin
                    if (head[k] >= q.size()) begin
                        chk("unexpected_valid", k, 32'd1, 32'd0);
                    end else begin
                        e = q[head[k]];
                        chk("latency", k, 32'(cyc), 32'(e.t + N + lat_of(k) + 1));
                        chk("rd_count", k, 32'(rdcnt[k]), 32'(N));
                        chk("busy_at_valid", k, 32'(busy[k]), 32'd0);
                        chk("class_idx", k, 32'(class_idx[k]), 32'(e.idx));
                        chk("class_score", k, 32'(class_score[k]), 32'(e.score));
`ifdef CLASS_ARGMAX_RUNNER_UP_EN
                        chk("second_idx", k, 32'(second_idx[k]), 32'(e.sidx));
                        chk("margin", k, 32'(margin[k]), 32'(e.margin));
`endif
                    end
                    rdcnt[k] = 0;
                end
                if (out_valid[k]) begin
                    vcnt[k]++;
                    if (vcnt[k] > 1 && head[k] < q.size())
                        chk("hold_stable", k, 32'({class_idx[k], class_score[k]}),
                            32'({q[head[k]].idx, q[head[k]].score}));
                end
                if (!out_valid[k] && pv_prev[k]) begin
                    if (head[k] < q.size()) begin
                        chk("done_length", k, 32'(vcnt[k]), 32'(q[head[k]].w + 1));
                        head[k]++;
                    end
                    vcnt[k] = 0;
                end
                pv_prev[k] = out_valid[k];
                w = (head[k] < q.size()) ? q[head[k]].w : 0;
                out_ready[k] = out_valid[k] ? (vcnt[k] > w) : (w == 0);
            end
        end
    end

    task automatic wait_idle();
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (!busy[0] && !busy[1] && !out_valid[0] && !out_valid[1]
                && head[0] == q.size() && head[1] == q.size()) return;
        end
        chk("idle_timeout", 0, 32'd1, 32'd0);
    endtask

    // pa/pb: extra start pulses sampled at edge T+pa / T+pb (0 = none).
    task automatic frame(input int w, input int pa, input int pb);
        exp_t e;
        wait_idle();
        e = ref_model(w);
        start = 1'b1;
        e.t = cyc + 1;
        q.push_back(e);
        @(posedge clk); #1;
        for (int c = 1; c <= 20; c++) begin
            start = (c == pa || c == pb);
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic abort_frame();
        exp_t e;
        wait_idle();
        e = ref_model(0);
        start = 1'b1;
        e.t = cyc + 1;
        q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++)
            mem[i] = ($urandom_range(0, 1) == 1) ? DW'($urandom_range(0, 3) << 8) : DW'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        mem[0] = 16'h0010; mem[1] = 16'h0080; mem[2] = 16'h0040;
        frame(0, 0, 0);

        for (int i = 0; i < 16; i++) mem[i] = 16'h8000;
        mem[9] = 16'hFFFF;
        frame(0, 13, 0);

        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[3] = 16'h0100; mem[7] = 16'h0100;
        frame(0, 0, 0);

        fill_random();
        frame(5, 4, 15);

        for (int i = 0; i < 16; i++) mem[i] = 16'h8000;
        frame(1, 0, 0);

        fill_random();
        abort_frame();
        fill_random();
        frame(0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            mem[i] = DW'($urandom);
            if (mem[i] == 16'h7FFF) mem[i] = '0;
        end
        mem[5] = 16'h7FFF;
        frame(2, 0, 0);

        for (int f = 0; f < 25; f++) begin
            fill_random();
            frame($urandom_range(0, 3), 0, 0);
        end

        wait_idle();
        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (checks %0d, failures %0d)", n_chk, n_fail);
        $fatal(1);
    end

endmodule
`default_nettype wire
